sdram_wr_burst: RTL
===================

Name: sdram_wr_burst

Overview:
- Downstream consumer of the write-data FIFO (fifo_16x8) in the SDRAM controller.
- Waits until the FIFO holds one full burst, then requests the SDRAM bus from the arbiter.
- Once granted, issues ACTIVE / WRITE / PRECHARGE, draining BURST_LEN words from the FIFO onto the SDRAM DQ bus.
- Keeps its own linear bank/row/column write pointer.

Parameters:
- DATA_W, 8: FIFO/SDRAM data width.
- FIFO_CNT_W, 5: width of the FIFO fill count (16-deep FIFO).
- BURST_LEN, 4: words per burst; must match the burst length programmed into the SDRAM mode register.
- TRCD, 2: cycles from ACTIVE to WRITE (≥2).
- TWR, 2: cycles from last data word to PRECHARGE (≥1).
- TRP, 2: cycles from PRECHARGE to burst end (≥1).
- ROW_W, 13: row address width.
- COL_W, 9: column address width.
- BANK_W, 2: bank address width.

Ports:
- sclk, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- fifo_cnt, input, FIFO_CNT_W: current FIFO fill level.
- fifo_rd_en, output, 1: FIFO read strobe.
- fifo_dout, input, DATA_W: FIFO read data, valid one cycle after fifo_rd_en.
- ref_req, input, 1: refresh pending; blocks the start of a new burst.
- wr_req, output, 1: bus request to the arbiter.
- wr_grant, input, 1: arbiter grant.
- addr_clr, input, 1: synchronous reset of the write pointer; honoured only in IDLE.
- sdram_cmd, output, 4: {cs_n, ras_n, cas_n, we_n}.
- sdram_ba, output, BANK_W: bank address.
- sdram_addr, output, ROW_W: multiplexed row/column address.
- sdram_dq, output, DATA_W: write data.
- sdram_dq_oe, output, 1: DQ output enable.
- wr_end, output, 1: single-cycle pulse when a burst completes.

Behaviour:
- Reset (asynchronous, immediate, also mid-burst):
  - State = IDLE.
  - sdram_cmd = NOP (4'b0111); sdram_ba = 0; sdram_addr = 0; sdram_dq = 0.
  - sdram_dq_oe = 0; fifo_rd_en = 0; wr_req = 0; wr_end = 0.
  - Write pointer (bank, row, col) = 0.
- Command encodings: NOP 0111, ACTIVE 0011, WRITE 0100, PRECHARGE 0010. sdram_cmd = NOP in every cycle not listed below.
- States: IDLE → REQ → ACT → RCD → WR → WRR → PRE → RP → IDLE.
- IDLE:
  - Go to REQ when fifo_cnt ≥ BURST_LEN and ref_req = 0.
  - If addr_clr is high, clear the pointer and take priority over starting a burst that cycle.
- REQ:
  - wr_req = 1; wait for wr_grant.
  - ref_req is ignored after this point.
- Cycle timing, with A = ACTIVE cycle (first cycle after wr_grant is sampled high in REQ):
  - A: cmd = ACTIVE, ba = bank, addr = row.
  - A+1 .. A+TRCD-1: NOP.
  - A+TRCD: cmd = WRITE, ba = bank, addr = {zeros, col}, A10 = 0 (no auto-precharge).
  - Data cycles A+TRCD .. L, where L = A+TRCD+BURST_LEN-1: sdram_dq_oe = 1, sdram_dq = fifo_dout.
  - fifo_rd_en = 1 for exactly BURST_LEN cycles, A+TRCD-1 .. L-1, so FIFO data lands aligned with the WRITE command.
  - L+TWR: cmd = PRECHARGE, ba = bank, A10 = 0.
  - L+TWR+TRP: wr_end = 1 for one cycle, wr_req drops to 0 in that same cycle, state → IDLE.
- wr_req stays high continuously from REQ entry until the wr_end cycle. Deassertion of wr_grant mid-burst is ignored; one burst is completed per grant.
- Pointer update (in the wr_end cycle):
  - col += BURST_LEN, modulo 2^COL_W.
  - On col wrap to 0: row += 1.
  - On row wrap: bank += 1, modulo 2^BANK_W.
- FIFO underflow is impossible by construction: the burst starts only when fifo_cnt ≥ BURST_LEN. No empty check is made mid-burst.
- Width rule: sdram_addr is ROW_W bits; the column is zero-extended in WRITE; PRECHARGE drives addr = 0.

Test Plan:
- Basic burst (defaults), FIFO preloaded with 12,34,56,78, wr_grant returned 1 cycle after wr_req:
  - ACT at A with addr=0, ba=0.
  - WRITE at A+2 with col 0.
  - sdram_dq = 12,34,56,78 on A+2..A+5 with oe=1.
  - fifo_rd_en high A+1..A+4.
  - PRE at A+7.
  - wr_end pulse at A+9, wr_req low at A+9.
- Threshold: fifo_cnt=3 → wr_req stays 0 for 20 cycles; fifo_cnt goes to 4 → wr_req=1 next cycle.
- Refresh priority: fifo_cnt=8 with ref_req=1 → no wr_req. ref_req drops → wr_req rises.
  - ref_req reasserted after grant → the burst still completes all 4 words and PRE.
- Pointer wrap: force col=508, row=5 → this burst writes col 508; after wr_end the next burst ACT has row 6 and its WRITE has col 0.
  - Separately, row=8191 plus a col wrap → bank increments 0→1.
- Reset mid-burst: assert rst during the 2nd data cycle →
  - Same cycle: cmd=NOP, oe=0, fifo_rd_en=0, wr_req=0.
  - After release with fifo_cnt≥4, the next ACT uses row 0, col 0.
- addr_clr: after 3 bursts (col=12), pulse addr_clr in IDLE → next WRITE uses col 0.

Source files
------------

// File: rtl/sdram_wr_burst.sv
// SDRAM write-burst engine: drains one BURST_LEN burst from the write FIFO per arbiter grant,
// sequencing ACTIVE / WRITE / PRECHARGE and advancing a linear bank/row/column pointer.
module sdram_wr_burst #(
    parameter int DATA_W     = 8,
    parameter int FIFO_CNT_W = 5,
    parameter int BURST_LEN  = 4,
    parameter int TRCD       = 2,
    parameter int TWR        = 2,
    parameter int TRP        = 2,
    parameter int ROW_W      = 13,
    parameter int COL_W      = 9,
    parameter int BANK_W     = 2
) (
    input  logic                  sclk,
    input  logic                  rst,
    input  logic [FIFO_CNT_W-1:0] fifo_cnt,
    output logic                  fifo_rd_en,
    input  logic [DATA_W-1:0]     fifo_dout,
    input  logic                  ref_req,
    output logic                  wr_req,
    input  logic                  wr_grant,
    input  logic                  addr_clr,
    output logic [3:0]            sdram_cmd,
    output logic [BANK_W-1:0]     sdram_ba,
    output logic [ROW_W-1:0]      sdram_addr,
    output logic [DATA_W-1:0]     sdram_dq,
    output logic                  sdram_dq_oe,
    output logic                  wr_end
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_ACT, S_RCD, S_WR, S_WRR, S_PRE, S_RP
    } state_t;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;

    localparam int CNT_MAX = (TRCD > BURST_LEN) ? ((TRCD > TWR) ? TRCD : TWR)
                                                : ((BURST_LEN > TWR) ? BURST_LEN : TWR);
    localparam int CNT_W   = $clog2(((CNT_MAX > TRP) ? CNT_MAX : TRP) + 1);

    // Each phase counter counts from 0 up to the value below, then the FSM moves on.
    localparam logic [CNT_W-1:0]      RCD_LAST  = CNT_W'(TRCD - 2);
    localparam logic [CNT_W-1:0]      WR_LAST   = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]      WRR_LAST  = CNT_W'((TWR > 1) ? TWR - 2 : 0);
    localparam logic [CNT_W-1:0]      RP_LAST   = CNT_W'(TRP - 1);
    localparam logic [FIFO_CNT_W-1:0] BURST_THR = FIFO_CNT_W'(BURST_LEN);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BANK_W-1:0]  bank_q;
    logic [ROW_W-1:0]   row_q;
    logic [COL_W-1:0]   col_q;
    logic [COL_W:0]     col_sum;
    logic [ROW_W:0]     row_sum;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output and next-state variable gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        fifo_rd_en  = 1'b0;
        wr_req      = 1'b0;
        wr_end      = 1'b0;
        sdram_cmd   = CMD_NOP;
        sdram_ba    = '0;
        sdram_addr  = '0;
        sdram_dq    = '0;
        sdram_dq_oe = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!addr_clr && !ref_req && fifo_cnt >= BURST_THR) state_d = S_REQ;
            end
            S_REQ: begin
                wr_req = 1'b1;
                cnt_d  = '0;
                if (wr_grant) state_d = S_ACT;
            end
            S_ACT: begin
                wr_req     = 1'b1;
                sdram_cmd  = CMD_ACT;
                sdram_ba   = bank_q;
                sdram_addr = row_q;
                cnt_d      = '0;
                state_d    = S_RCD;
            end
            S_RCD: begin
                wr_req = 1'b1;
                // First FIFO read one cycle early so its data lines up with WRITE.
                if (cnt_q == RCD_LAST) begin
                    fifo_rd_en = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_WR;
                end
            end
            S_WR: begin
                wr_req      = 1'b1;
                sdram_dq_oe = 1'b1;
                sdram_dq    = fifo_dout;
                if (cnt_q == '0) begin
                    sdram_cmd  = CMD_WRITE;
                    sdram_ba   = bank_q;
                    sdram_addr = ROW_W'(col_q);  // zero-extended, so A10 (auto-precharge) stays 0
                end
                if (cnt_q != WR_LAST) begin
                    fifo_rd_en = 1'b1;
                end else begin
                    cnt_d   = '0;
                    state_d = (TWR > 1) ? S_WRR : S_PRE;
                end
            end
            S_WRR: begin
                wr_req = 1'b1;
                if (cnt_q == WRR_LAST) begin
                    cnt_d   = '0;
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                wr_req    = 1'b1;
                sdram_cmd = CMD_PRE;
                sdram_ba  = bank_q;
                cnt_d     = '0;
                state_d   = S_RP;
            end
            S_RP: begin
                if (cnt_q == RP_LAST) begin
                    wr_end  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    wr_req = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Linear pointer: column carries into row, row carries into bank.
    assign col_sum = {1'b0, col_q} + (COL_W + 1)'(BURST_LEN);
    assign row_sum = {1'b0, row_q} + (ROW_W + 1)'(col_sum[COL_W]);

    // NOTE: the pointer is plain flops, so it is cleared by the async reset like the FSM.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            bank_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
        end else if (state_q == S_IDLE && addr_clr) begin
            bank_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
        end else if (wr_end) begin
            col_q <= col_sum[COL_W-1:0];
            row_q <= row_sum[ROW_W-1:0];
            if (row_sum[ROW_W]) bank_q <= bank_q + 1'b1;
        end
    end

endmodule
